// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: control inputs, instruction-memory port and IF/ID register outputs.
// master = fetch stage, slave = surrounding pipeline / memory / testbench.
interface fetch_stage_if;
  logic        Stall;
  logic        Branch_Taken;
  logic [15:0] Branch_Target;
  logic        Halt;
  logic [15:0] IM_Data;
  logic [15:0] Input_Address;
  logic [15:0] IF_ID_Instruction;
  logic [15:0] IF_ID_PC;
  logic [15:0] IF_ID_PC_Plus2;
  logic        IF_ID_Valid;
  logic        Align_Error;
  logic [15:0] Fetch_Count;

  modport master (
    input  Stall, Branch_Taken, Branch_Target, Halt, IM_Data,
    output Input_Address, IF_ID_Instruction, IF_ID_PC, IF_ID_PC_Plus2,
           IF_ID_Valid, Align_Error, Fetch_Count
  );

  modport slave (
    output Stall, Branch_Taken, Branch_Target, Halt, IM_Data,
    input  Input_Address, IF_ID_Instruction, IF_ID_PC, IF_ID_PC_Plus2,
           IF_ID_Valid, Align_Error, Fetch_Count
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, combinational IM address, IF/ID capture
// with stall, branch redirect (1-bubble squash) and halt.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd2
) (
  input  logic          Clock,
  input  logic          Reset,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {BOOT, FETCH, HALTED} state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_pc,     w_pc_nxt;
  logic [15:0] r_instr,  w_instr_nxt;
  logic [15:0] r_if_pc,  w_if_pc_nxt;
  logic [15:0] r_if_pc2, w_if_pc2_nxt;
  logic        r_valid,  w_valid_nxt;
  logic        r_align,  w_align_nxt;
  logic [15:0] r_count,  w_count_nxt;
  logic [15:0] w_pc_inc;

  assign w_pc_inc = r_pc + PC_STEP;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_state <= BOOT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_instr_nxt  = r_instr;
    w_if_pc_nxt  = r_if_pc;
    w_if_pc2_nxt = r_if_pc2;
    w_valid_nxt  = r_valid;
    w_align_nxt  = r_align;
    w_count_nxt  = r_count;
    case (r_state)
      BOOT: begin
        // One idle cycle out of reset; only Halt is honoured here.
        w_state_nxt = bus.Halt ? HALTED : FETCH;
        w_valid_nxt = 1'b0;
      end
      FETCH: begin
        if (bus.Halt) begin
          w_state_nxt = HALTED;
          w_valid_nxt = 1'b0;
        end else if (bus.Branch_Taken) begin
          // Redirect wins over Stall; the instruction fetched this cycle is wrong-path.
          w_pc_nxt    = {bus.Branch_Target[15:1], 1'b0};
          w_valid_nxt = 1'b0;
          if (bus.Branch_Target[0]) w_align_nxt = 1'b1;
        end else if (!bus.Stall) begin
          w_instr_nxt  = bus.IM_Data;
          w_if_pc_nxt  = r_pc;
          w_if_pc2_nxt = w_pc_inc;
          w_valid_nxt  = 1'b1;
          w_pc_nxt     = w_pc_inc;
          w_count_nxt  = r_count + 16'd1;
        end
      end
      HALTED: begin
        w_valid_nxt = 1'b0;
      end
      default: begin
        w_state_nxt = BOOT;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_pc     <= RESET_PC;
      r_instr  <= 16'h0000;
      r_if_pc  <= 16'h0000;
      r_if_pc2 <= 16'h0000;
      r_valid  <= 1'b0;
      r_align  <= 1'b0;
      r_count  <= 16'h0000;
    end else begin
      r_pc     <= w_pc_nxt;
      r_instr  <= w_instr_nxt;
      r_if_pc  <= w_if_pc_nxt;
      r_if_pc2 <= w_if_pc2_nxt;
      r_valid  <= w_valid_nxt;
      r_align  <= w_align_nxt;
      r_count  <= w_count_nxt;
    end
  end

  assign bus.Input_Address     = r_pc;
  assign bus.IF_ID_Instruction = r_instr;
  assign bus.IF_ID_PC          = r_if_pc;
  assign bus.IF_ID_PC_Plus2    = r_if_pc2;
  assign bus.IF_ID_Valid       = r_valid;
  assign bus.Align_Error       = r_align;
  assign bus.Fetch_Count       = r_count;

endmodule
